// File: rtl/bram_lsu_master.sv
// rtl/bram_lsu_master.sv - load/store initiator for the data_mem BRAM port B
//
// Purpose:
//   Turns one core load/store request (byte/half/word, signed/unsigned) into
//   enb/web/addrb/dinb beats on a 1-cycle registered-read BRAM. It then aligns
//   and extends the returned word. Requests are range-checked against
//   [MEM_OFFSET, MEM_OFFSET+MEM_BYTES). Misaligned or illegal-size requests are
//   answered with an error and never touch the BRAM.
//
// Optional feature macro: LSU_SPLIT_MISALIGN_EN
//   Undefined: a misaligned half or word is an error.
//   Defined:   an access that crosses a word boundary is split into two
//              consecutive beats (W, then W+4).
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err one-cycle response, no backpressure
//   data_mem_*                    BRAM port B pins (clkb = clk, rstb tied 0)

module bram_lsu_master #(
  parameter logic [31:0] MEM_OFFSET = 32'h0000_0600,
  parameter int unsigned MEM_BYTES  = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        data_mem_clkb,
  output logic        data_mem_enb,
  output logic        data_mem_rstb,
  output logic [3:0]  data_mem_web,
  output logic [31:0] data_mem_addrb,
  output logic [31:0] data_mem_dinb,
  input  logic [31:0] data_mem_doutb,
  input  logic        data_mem_rstb_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, ISSUE2, CAPTURE, RESP, ERR} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;

  logic        accept;
  logic [31:0] off;
  logic [32:0] end_off;
  logic [2:0]  size_bytes;
  logic [3:0]  size_mask;
  logic [31:0] rep_data;
  logic [63:0] rep_rot;
  logic        misalign;
  logic        req_err;
  logic [31:0] rd_lane;
  logic [31:0] ld_data;

  assign data_mem_clkb = clk;
  assign data_mem_rstb = 1'b0;

  // RESP is the last cycle of a transaction; accepting there lets a new
  // request start back-to-back with the previous response.
  assign req_ready = ((state == IDLE) || (state == RESP)) & ~data_mem_rstb_busy & ~reset;
  assign accept    = req_valid & req_ready;

  always_comb begin
    size_bytes = 3'd4;
    size_mask  = 4'b1111;
    rep_data   = req_wdata;
    case (req_size)
      2'b00: begin
        size_bytes = 3'd1;
        size_mask  = 4'b0001;
        rep_data   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        size_bytes = 3'd2;
        size_mask  = 4'b0011;
        rep_data   = {2{req_wdata[15:0]}};
      end
      default: begin
        size_bytes = 3'd4;
        size_mask  = 4'b1111;
        rep_data   = req_wdata;
      end
    endcase
  end

  // Unsigned wrap of off makes addresses below MEM_OFFSET look huge, so one
  // compare covers both ends of the window. 33 bits keep off+size from wrapping.
  assign off     = req_addr - MEM_OFFSET;
  assign end_off = {1'b0, off} + {30'd0, size_bytes};

  // Replicated store data rotated into byte lanes; for aligned accesses the
  // rotation is the identity, for split accesses it places the low bytes at
  // the top of word W and the high bytes at the bottom of word W+4.
  assign rep_rot = {rep_data, rep_data} << {req_addr[1:0], 3'b000};

`ifdef LSU_SPLIT_MISALIGN_EN
  logic        span;
  logic        span_q;
  logic [7:0]  web_pair;
  logic [3:0]  web_hi_q;
  logic [31:0] lo_q;

  assign span     = ((req_size == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign misalign = 1'b0;
  assign web_pair = {4'b0000, size_mask} << req_addr[1:0];
  assign rd_lane  = 32'((span_q ? {data_mem_doutb, lo_q} : {32'd0, data_mem_doutb})
                        >> {lane_q, 3'b000});
`else
  logic [3:0] web_first;

  assign misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign web_first = size_mask << req_addr[1:0];
  assign rd_lane   = data_mem_doutb >> {lane_q, 3'b000};
`endif

  assign req_err = (req_size == 2'b11) || misalign || (end_off > 33'(MEM_BYTES));

  always_comb begin
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & rd_lane[7]}}, rd_lane[7:0]};
      2'b01:   ld_data = {{16{~uns_q & rd_lane[15]}}, rd_lane[15:0]};
      default: ld_data = rd_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      data_mem_enb   <= 1'b0;
      data_mem_web   <= 4'b0000;
      data_mem_addrb <= 32'd0;
      data_mem_dinb  <= 32'd0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 32'd0;
      rsp_err        <= 1'b0;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      size_q         <= 2'b00;
      lane_q         <= 2'b00;
`ifdef LSU_SPLIT_MISALIGN_EN
      span_q         <= 1'b0;
      web_hi_q       <= 4'b0000;
      lo_q           <= 32'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      case (state)
        IDLE, RESP: begin
          state <= IDLE;
          if (accept) begin
            we_q   <= req_we;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            lane_q <= req_addr[1:0];
            if (req_err) begin
              state     <= ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state          <= ISSUE;
              data_mem_enb   <= 1'b1;
              data_mem_addrb <= {off[31:2], 2'b00};
              data_mem_dinb  <= req_we ? rep_rot[63:32] : 32'd0;
`ifdef LSU_SPLIT_MISALIGN_EN
              span_q         <= span;
              data_mem_web   <= req_we ? web_pair[3:0] : 4'b0000;
              web_hi_q       <= req_we ? web_pair[7:4] : 4'b0000;
`else
              data_mem_web   <= req_we ? web_first : 4'b0000;
`endif
            end
          end
        end
        ISSUE: begin
`ifdef LSU_SPLIT_MISALIGN_EN
          if (span_q) begin
            state          <= ISSUE2;
            data_mem_addrb <= data_mem_addrb + 32'd4;
            data_mem_web   <= web_hi_q;
          end else begin
            state        <= CAPTURE;
            data_mem_enb <= 1'b0;
            data_mem_web <= 4'b0000;
          end
`else
          state        <= CAPTURE;
          data_mem_enb <= 1'b0;
          data_mem_web <= 4'b0000;
`endif
        end
`ifdef LSU_SPLIT_MISALIGN_EN
        ISSUE2: begin
          // First word of the split read is on doutb now.
          state        <= CAPTURE;
          data_mem_enb <= 1'b0;
          data_mem_web <= 4'b0000;
          lo_q         <= data_mem_doutb;
        end
`endif
        CAPTURE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= we_q ? 32'd0 : ld_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_lsu_master.sv
// tb/tb_bram_lsu_master.sv - directed self-checking bench for bram_lsu_master
//
// Purpose: drives directed load/store vectors into bram_lsu_master with a
// behavioural 1-cycle registered-read BRAM attached, and compares responses
// and BRAM beats against hand-computed values.
// Ports: none (top-level bench).

module tb_bram_lsu_master;

  logic        tb_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        data_mem_clkb;
  logic        data_mem_enb;
  logic        data_mem_rstb;
  logic [3:0]  data_mem_web;
  logic [31:0] data_mem_addrb;
  logic [31:0] data_mem_dinb;
  logic [31:0] data_mem_doutb = 32'd0;
  logic        data_mem_rstb_busy = 1'b0;

  always #5 tb_clk = ~tb_clk;

  bram_lsu_master dut (
    .clk                (tb_clk),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_we             (req_we),
    .req_size           (req_size),
    .req_unsigned       (req_unsigned),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .data_mem_clkb      (data_mem_clkb),
    .data_mem_enb       (data_mem_enb),
    .data_mem_rstb      (data_mem_rstb),
    .data_mem_web       (data_mem_web),
    .data_mem_addrb     (data_mem_addrb),
    .data_mem_dinb      (data_mem_dinb),
    .data_mem_doutb     (data_mem_doutb),
    .data_mem_rstb_busy (data_mem_rstb_busy)
  );

  // Behavioural BRAM: 4096 words, byte writes, registered read.
  logic [31:0] mem [0:4095] = '{default: 32'd0};
  always @(posedge tb_clk) begin
    if (data_mem_enb) begin
      for (int i = 0; i < 4; i++)
        if (data_mem_web[i]) mem[data_mem_addrb[13:2]][8*i +: 8] <= data_mem_dinb[8*i +: 8];
      data_mem_doutb <= mem[data_mem_addrb[13:2]];
    end
  end

  // Beat and response monitor, sampled on the falling edge.
  int          cyc = 0;
  int          beat_n = 0;
  int          rsp_n = 0;
  int          beat_cyc [0:255];
  logic [31:0] beat_addr [0:255];
  logic [3:0]  beat_web [0:255];
  logic [31:0] beat_din [0:255];
  always @(posedge tb_clk) cyc <= cyc + 1;
  always @(negedge tb_clk) begin
    if (data_mem_enb) begin
      if (beat_n < 256) begin
        beat_cyc[beat_n]  = cyc;
        beat_addr[beat_n] = data_mem_addrb;
        beat_web[beat_n]  = data_mem_web;
        beat_din[beat_n]  = data_mem_dinb;
      end
      beat_n = beat_n + 1;
    end
    if (rsp_valid) rsp_n = rsp_n + 1;
  end

  int          n_cmp = 0;
  int          n_fail = 0;
  int          r_lat;
  int          r_t1;
  int          r_b0;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_rdy;

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int k;
    k = 0;
    while (!req_ready && k < 20) begin tick(); k++; end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", req_addr, req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // Issues one request and waits (bounded) for its response.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    r_b0 = beat_n;
    drive(we, size, uns, addr, wdata);
    wait_accept();
    r_t1 = cyc;
    r_lat = 0; r_rdata = 'x; r_err = 'x; r_rdy = 'x;
    for (int c = 1; c <= 8; c++) begin
      if (rsp_valid) begin
        r_lat = c; r_rdata = rsp_rdata; r_err = rsp_err; r_rdy = req_ready;
        break;
      end
      tick();
    end
    if (r_lat == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout addr=%h no rsp_valid within 8 cycles", addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({data_mem_enb, data_mem_web, rsp_valid, rsp_err, req_ready} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctl got enb=%b web=%b rv=%b re=%b rdy=%b required all 0",
               data_mem_enb, data_mem_web, rsp_valid, rsp_err, req_ready);
    end
    n_cmp++;
    if ({data_mem_addrb, data_mem_dinb, rsp_rdata} !== 96'd0) begin
      n_fail++;
      $display("FAIL reset_data got addrb=%h dinb=%h rdata=%h required 0",
               data_mem_addrb, data_mem_dinb, rsp_rdata);
    end
    n_cmp++;
    if (data_mem_rstb !== 1'b0) begin
      n_fail++; $display("FAIL rstb_tie got %b required 0", data_mem_rstb);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset got %b required 1", req_ready);
    end
  endtask

  task automatic test_store_word();
    run_req(1'b1, 2'b10, 1'b0, 32'h600, 32'hDEADBEEF);
    n_cmp++;
    if (r_lat !== 3 || r_err !== 1'b0 || r_rdata !== 32'd0 || r_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_rsp got lat=%0d err=%b rdata=%h rdy=%b required 3 0 0 1",
               r_lat, r_err, r_rdata, r_rdy);
    end
    n_cmp++;
    if (beat_n - r_b0 !== 1 || beat_cyc[r_b0] !== r_t1) begin
      n_fail++;
      $display("FAIL sw_beat got beats=%0d cyc=%0d required 1 at %0d", beat_n - r_b0,
               beat_cyc[r_b0], r_t1);
    end
    n_cmp++;
    if (beat_addr[r_b0] !== 32'h0 || beat_web[r_b0] !== 4'b1111 || beat_din[r_b0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL sw_pins got addrb=%h web=%b dinb=%h required 0 1111 deadbeef",
               beat_addr[r_b0], beat_web[r_b0], beat_din[r_b0]);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] addrs [5] = '{32'h603, 32'h603, 32'h602, 32'h602, 32'h601};
    logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h00000022};
    run_req(1'b1, 2'b10, 1'b0, 32'h600, 32'h80112233);
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, sizes[i], unss[i], addrs[i], 32'd0);
      n_cmp++;
      if (r_rdata !== exps[i] || r_err !== 1'b0 || r_lat !== 3 || beat_web[r_b0] !== 4'b0000) begin
        n_fail++;
        $display("FAIL load_ext[%0d] got rdata=%h err=%b lat=%0d web=%b required %h 0 3 0000",
                 i, r_rdata, r_err, r_lat, beat_web[r_b0], exps[i]);
      end
    end
  endtask

  task automatic test_store_half_byte();
    run_req(1'b1, 2'b01, 1'b0, 32'h606, 32'h0000ABCD);
    n_cmp++;
    if (beat_addr[r_b0] !== 32'h4 || beat_web[r_b0] !== 4'b1100 || beat_din[r_b0] !== 32'hABCDABCD) begin
      n_fail++;
      $display("FAIL sh_pins got addrb=%h web=%b dinb=%h required 4 1100 abcdabcd",
               beat_addr[r_b0], beat_web[r_b0], beat_din[r_b0]);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h604, 32'd0);
    n_cmp++;
    if (r_rdata !== 32'hABCD0000) begin
      n_fail++; $display("FAIL sh_readback got %h required abcd0000", r_rdata);
    end
    run_req(1'b1, 2'b00, 1'b0, 32'h605, 32'h1234565A);
    n_cmp++;
    if (beat_web[r_b0] !== 4'b0010 || beat_din[r_b0] !== 32'h5A5A5A5A) begin
      n_fail++;
      $display("FAIL sb_pins got web=%b dinb=%h required 0010 5a5a5a5a",
               beat_web[r_b0], beat_din[r_b0]);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h604, 32'd0);
    n_cmp++;
    if (r_rdata !== 32'hABCD5A00) begin
      n_fail++; $display("FAIL sb_readback got %h required abcd5a00", r_rdata);
    end
  endtask

  task automatic test_range();
    logic        wes   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sizes [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b00};
    logic [31:0] addrs [5] = '{32'h5FC, 32'h4600, 32'h600, 32'h0, 32'h45FF};
    logic        errs  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_req(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF);
      n_cmp++;
      if (r_err !== errs[i] || r_rdata !== 32'd0 || r_lat !== (errs[i] ? 1 : 3) ||
          (beat_n - r_b0) !== (errs[i] ? 0 : 1)) begin
        n_fail++;
        $display("FAIL range[%0d] got err=%b rdata=%h lat=%0d beats=%0d required err=%b rdata=0",
                 i, r_err, r_rdata, r_lat, beat_n - r_b0, errs[i]);
      end
    end
    // Boundary word at the last legal address.
    run_req(1'b0, 2'b10, 1'b0, 32'h45FC, 32'd0);
    n_cmp++;
    if (r_err !== 1'b0 || r_lat !== 3 || beat_addr[r_b0] !== 32'h3FFC) begin
      n_fail++;
      $display("FAIL range_top got err=%b lat=%0d addrb=%h required 0 3 3ffc",
               r_err, r_lat, beat_addr[r_b0]);
    end
  endtask

  task automatic test_misalign();
    run_req(1'b1, 2'b10, 1'b0, 32'h600, 32'h44332211);
    run_req(1'b1, 2'b10, 1'b0, 32'h604, 32'h88776655);
    run_req(1'b0, 2'b10, 1'b0, 32'h601, 32'd0);
`ifdef LSU_SPLIT_MISALIGN_EN
    n_cmp++;
    if (r_err !== 1'b0 || r_lat !== 4 || r_rdata !== 32'h55443322 || beat_n - r_b0 !== 2 ||
        beat_addr[r_b0] !== 32'h0 || beat_addr[r_b0 + 1] !== 32'h4) begin
      n_fail++;
      $display("FAIL split_word got err=%b lat=%0d rdata=%h beats=%0d required 0 4 55443322 2",
               r_err, r_lat, r_rdata, beat_n - r_b0);
    end
    run_req(1'b0, 2'b01, 1'b0, 32'h601, 32'd0);
    n_cmp++;
    if (r_err !== 1'b0 || r_lat !== 3 || r_rdata !== 32'h00003322) begin
      n_fail++;
      $display("FAIL half01 got err=%b lat=%0d rdata=%h required 0 3 00003322", r_err, r_lat, r_rdata);
    end
`else
    n_cmp++;
    if (r_err !== 1'b1 || r_lat !== 1 || r_rdata !== 32'd0 || beat_n - r_b0 !== 0) begin
      n_fail++;
      $display("FAIL misalign_word got err=%b lat=%0d rdata=%h beats=%0d required 1 1 0 0",
               r_err, r_lat, r_rdata, beat_n - r_b0);
    end
    run_req(1'b0, 2'b01, 1'b0, 32'h601, 32'd0);
    n_cmp++;
    if (r_err !== 1'b1 || r_lat !== 1 || beat_n - r_b0 !== 0) begin
      n_fail++;
      $display("FAIL misalign_half got err=%b lat=%0d beats=%0d required 1 1 0",
               r_err, r_lat, beat_n - r_b0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 2'b10, 1'b0, 32'h604, 32'd0);
    n_cmp++;
    if (r_rdata !== 32'h88776655 || r_rdy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first got rdata=%h rdy=%b required 88776655 1", r_rdata, r_rdy);
    end
    drive(1'b0, 2'b10, 1'b0, 32'h600, 32'd0);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h44332211) begin
      n_fail++;
      $display("FAIL b2b_second got rv=%b rdata=%h required 1 44332211", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_busy();
    data_mem_rstb_busy = 1'b1;
    r_b0 = beat_n;
    drive(1'b0, 2'b10, 1'b0, 32'h600, 32'd0);
    tick(); tick(); tick();
    n_cmp++;
    if (req_ready !== 1'b0 || beat_n - r_b0 !== 0) begin
      n_fail++;
      $display("FAIL busy_block got rdy=%b beats=%0d required 0 0", req_ready, beat_n - r_b0);
    end
    data_mem_rstb_busy = 1'b0;
    wait_accept();
    data_mem_rstb_busy = 1'b1;
    tick(); tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h44332211) begin
      n_fail++;
      $display("FAIL busy_inflight got rv=%b rdata=%h required 1 44332211", rsp_valid, rsp_rdata);
    end
    data_mem_rstb_busy = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int rsp0;
    rsp0 = rsp_n;
    drive(1'b1, 2'b10, 1'b0, 32'h608, 32'h12345678);
    wait_accept();
    reset = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b0 || data_mem_enb !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_t1 got rdy=%b enb=%b required 0 1", req_ready, data_mem_enb);
    end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (data_mem_enb !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_t2 got enb=%b rdy=%b rv=%b required 0 1 0",
               data_mem_enb, req_ready, rsp_valid);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (rsp_n !== rsp0) begin
      n_fail++; $display("FAIL rst_mid_drop got %0d responses required 0", rsp_n - rsp0);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h608, 32'd0);
    n_cmp++;
    if (r_lat !== 3 || r_err !== 1'b0 || r_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rst_mid_after got lat=%0d err=%b rdata=%h required 3 0 12345678",
               r_lat, r_err, r_rdata);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_store_word();
    test_load_extend();
    test_store_half_byte();
    test_range();
    test_misalign();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
